// File: rtl/traffic_light_ctrl.sv
// rtl/traffic_light_ctrl.sv - two-road intersection light sequencer driving a BCD countdown timer
//
// Purpose:
//   Steps the north-south / east-west lamps through a fixed phase ring.
//   On every phase entry it presents the phase duration as two BCD digits
//   and pulses tmr_start for one cycle. It then waits for tmr_time_out
//   before taking the next step. An emergency level parks the junction
//   all-red in HOLD. HOLD is also the reset state.
//
// Build option:
//   PED_REQ_EN - when defined, adds a latched pedestrian request and a WALK
//                phase. WALK is inserted between AR_B and NS_G when a request
//                is pending.
//
// Ports:
//   clk           in  1  rising-edge clock
//   rst_n         in  1  synchronous reset, ACTIVE HIGH despite the name
//   emergency     in  1  level, hold all approaches red while high
//   ped_req       in  1  pedestrian button (ignored without PED_REQ_EN)
//   tmr_time_out  in  1  one-cycle pulse, timer reached 00
//   tmr_start     out 1  one-cycle load/start pulse to the timer
//   tmr_tens      out 4  BCD tens digit of current phase duration
//   tmr_ones      out 4  BCD ones digit of current phase duration
//   ns_light      out 3  {red, yellow, green} one-hot, north-south
//   ew_light      out 3  {red, yellow, green} one-hot, east-west
//   walk          out 1  pedestrian walk lamp
//   state_dbg     out 3  current state encoding
module traffic_light_ctrl #(
  parameter int T_GREEN  = 25,
  parameter int T_YELLOW = 3,
  parameter int T_ALLRED = 2,
  parameter int T_WALK   = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       emergency,
  input  logic       ped_req,
  input  logic       tmr_time_out,
  output logic       tmr_start,
  output logic [3:0] tmr_tens,
  output logic [3:0] tmr_ones,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic [2:0] state_dbg
);

  // Durations have to fit in two BCD digits and must be non-zero.
  // A zero load would make the timer time out immediately.
  if (T_GREEN < 1 || T_GREEN > 99) begin : g_bad_green
    $error("traffic_light_ctrl: T_GREEN must be 1..99");
  end
  if (T_YELLOW < 1 || T_YELLOW > 99) begin : g_bad_yellow
    $error("traffic_light_ctrl: T_YELLOW must be 1..99");
  end
  if (T_ALLRED < 1 || T_ALLRED > 99) begin : g_bad_allred
    $error("traffic_light_ctrl: T_ALLRED must be 1..99");
  end
  if (T_WALK < 1 || T_WALK > 99) begin : g_bad_walk
    $error("traffic_light_ctrl: T_WALK must be 1..99");
  end

  typedef enum logic [2:0] {
    ST_AR_B = 3'd0,
    ST_NS_G = 3'd1,
    ST_NS_Y = 3'd2,
    ST_AR_A = 3'd3,
    ST_EW_G = 3'd4,
    ST_EW_Y = 3'd5,
    ST_WALK = 3'd6,
    ST_HOLD = 3'd7
  } state_e;

  // Lamp encodings, {red, yellow, green}.
  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  // Elaboration-time binary to BCD conversion of the durations.
  localparam logic [3:0] GREEN_TENS  = 4'(T_GREEN / 10);
  localparam logic [3:0] GREEN_ONES  = 4'(T_GREEN % 10);
  localparam logic [3:0] YELLOW_TENS = 4'(T_YELLOW / 10);
  localparam logic [3:0] YELLOW_ONES = 4'(T_YELLOW % 10);
  localparam logic [3:0] ALLRED_TENS = 4'(T_ALLRED / 10);
  localparam logic [3:0] ALLRED_ONES = 4'(T_ALLRED % 10);
  localparam logic [3:0] WALK_TENS   = 4'(T_WALK / 10);
  localparam logic [3:0] WALK_ONES   = 4'(T_WALK % 10);

  state_e     state_q, state_d;
  logic       tmr_start_q, tmr_start_d;
  logic [3:0] tmr_tens_q, tmr_tens_d;
  logic [3:0] tmr_ones_q, tmr_ones_d;
  logic [2:0] ns_light_q, ns_light_d;
  logic [2:0] ew_light_q, ew_light_d;
  logic       walk_d;
  logic       timeout_ok;
  logic       go_walk;

  // A time-out is only honoured when the timer is not being reloaded in the
  // same cycle. A pulse arriving together with a start belongs to the old
  // count and would otherwise skip the phase just entered.
  assign timeout_ok = tmr_time_out && !tmr_start_q && (state_q != ST_HOLD);

`ifdef PED_REQ_EN
  logic ped_pending_q, ped_pending_d;
  logic walk_q;

  assign go_walk = ped_pending_q;

  // A request arriving on the same cycle as WALK entry is kept. That person
  // has missed this walk and gets the next one.
  always_comb begin
    ped_pending_d = ped_pending_q;
    if (state_d == ST_WALK && state_q != ST_WALK) begin
      ped_pending_d = 1'b0;
    end
    if (ped_req) begin
      ped_pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      ped_pending_q <= 1'b0;
      walk_q        <= 1'b0;
    end else begin
      ped_pending_q <= ped_pending_d;
      walk_q        <= walk_d;
    end
  end

  assign walk = walk_q;
`else
  logic unused_ped_req;

  assign unused_ped_req = ped_req;
  assign go_walk        = 1'b0;
  assign walk           = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // State and output registers. Reset (active high) overrides everything.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q     <= ST_HOLD;
      tmr_start_q <= 1'b0;
      tmr_tens_q  <= 4'd0;
      tmr_ones_q  <= 4'd0;
      ns_light_q  <= LAMP_RED;
      ew_light_q  <= LAMP_RED;
    end else begin
      state_q     <= state_d;
      tmr_start_q <= tmr_start_d;
      tmr_tens_q  <= tmr_tens_d;
      tmr_ones_q  <= tmr_ones_d;
      ns_light_q  <= ns_light_d;
      ew_light_q  <= ew_light_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic. Emergency beats a simultaneous time-out.
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (emergency) begin
      state_d = ST_HOLD;
    end else begin
      unique case (state_q)
        ST_HOLD: state_d = ST_AR_B;
        ST_AR_B: if (timeout_ok) state_d = go_walk ? ST_WALK : ST_NS_G;
        ST_NS_G: if (timeout_ok) state_d = ST_NS_Y;
        ST_NS_Y: if (timeout_ok) state_d = ST_AR_A;
        ST_AR_A: if (timeout_ok) state_d = ST_EW_G;
        ST_EW_G: if (timeout_ok) state_d = ST_EW_Y;
        ST_EW_Y: if (timeout_ok) state_d = ST_AR_B;
        ST_WALK: if (timeout_ok) state_d = ST_AR_B;
        default: state_d = ST_HOLD;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Output logic. Decoded from the state being entered and then
  // registered, so the lamps, digits and start pulse all change on the
  // same edge as the state. The ring has no self-loops. Any change into a
  // state other than HOLD is therefore a phase entry that needs a timer
  // load.
  // ---------------------------------------------------------------------
  always_comb begin
    tmr_start_d = (state_d != state_q) && (state_d != ST_HOLD);
    tmr_tens_d  = 4'd0;
    tmr_ones_d  = 4'd0;
    ns_light_d  = LAMP_RED;
    ew_light_d  = LAMP_RED;
    walk_d      = 1'b0;
    unique case (state_d)
      ST_NS_G: begin
        ns_light_d = LAMP_GRN;
        tmr_tens_d = GREEN_TENS;
        tmr_ones_d = GREEN_ONES;
      end
      ST_NS_Y: begin
        ns_light_d = LAMP_YEL;
        tmr_tens_d = YELLOW_TENS;
        tmr_ones_d = YELLOW_ONES;
      end
      ST_EW_G: begin
        ew_light_d = LAMP_GRN;
        tmr_tens_d = GREEN_TENS;
        tmr_ones_d = GREEN_ONES;
      end
      ST_EW_Y: begin
        ew_light_d = LAMP_YEL;
        tmr_tens_d = YELLOW_TENS;
        tmr_ones_d = YELLOW_ONES;
      end
      ST_AR_A, ST_AR_B: begin
        tmr_tens_d = ALLRED_TENS;
        tmr_ones_d = ALLRED_ONES;
      end
      ST_WALK: begin
        walk_d     = 1'b1;
        tmr_tens_d = WALK_TENS;
        tmr_ones_d = WALK_ONES;
      end
      default: begin
        tmr_tens_d = 4'd0;
        tmr_ones_d = 4'd0;
      end
    endcase
  end

`ifndef PED_REQ_EN
  logic unused_walk_d;

  assign unused_walk_d = walk_d;
`endif

  assign tmr_start = tmr_start_q;
  assign tmr_tens  = tmr_tens_q;
  assign tmr_ones  = tmr_ones_q;
  assign ns_light  = ns_light_q;
  assign ew_light  = ew_light_q;
  assign state_dbg = state_q;

endmodule

// File: doc/traffic_light_ctrl.md
# traffic_light_ctrl

Two-road intersection controller, the initiator side of the countdown-timer handshake. It sequences north-south and east-west lights through a fixed phase ring. On each phase entry it loads the BCD countdown timer with the phase duration and issues a start pulse, then advances on the timer's `time_out`. It sits between the BCD countdown timer and the lamp drivers. An optional pedestrian walk phase is compiled in with a macro.

## Interface
Parameters:
- `T_GREEN`, default 25: green duration, seconds, decimal 1..99.
- `T_YELLOW`, default 3: yellow duration, seconds, 1..99.
- `T_ALLRED`, default 2: all-red clearance, seconds, 1..99.
- `T_WALK`, default 10: walk duration, seconds, 1..99. Used only with `PED_REQ_EN`.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `rst_n` in 1: synchronous, active-high reset. The port name keeps the codebase's spelling; the polarity is high.
- `emergency` in 1: level; while high, all approaches are held red.
- `ped_req` in 1: pedestrian button, one or more cycles high. The port is always present.
- `tmr_time_out` in 1: one-cycle pulse from the timer when the count reaches 00.
- `tmr_start` out 1: one-cycle pulse that loads and starts the timer.
- `tmr_tens` out 4: BCD tens digit of the current phase duration.
- `tmr_ones` out 4: BCD ones digit of the current phase duration.
- `ns_light` out 3: {red, yellow, green}, one-hot.
- `ew_light` out 3: {red, yellow, green}, one-hot.
- `walk` out 1: pedestrian walk lamp.
- `state_dbg` out 3: current state encoding.

## Operation
- State encoding: 0 AR_B, 1 NS_G, 2 NS_Y, 3 AR_A, 4 EW_G, 5 EW_Y, 6 WALK, 7 HOLD.
- Phase ring: AR_B → NS_G → NS_Y → AR_A → EW_G → EW_Y → AR_B.
  - Each step is taken on `tmr_time_out`.
  - With `PED_REQ_EN` and `ped_pending`=1, AR_B goes to WALK instead of NS_G.
  - WALK returns to AR_B.
- Lamps per state:
  - NS_G: ns=001, ew=100.
  - NS_Y: ns=010, ew=100.
  - EW_G: ns=100, ew=001.
  - EW_Y: ns=100, ew=010.
  - AR_A, AR_B, WALK, HOLD: ns=100, ew=100.
  - `walk`=1 only in WALK.
- Durations:
  - NS_G, EW_G use T_GREEN; NS_Y, EW_Y use T_YELLOW; AR_A, AR_B use T_ALLRED; WALK uses T_WALK; HOLD drives 00.
  - Parameters are converted to BCD at elaboration: tens = T/10, ones = T%10.
  - Parameters outside 1..99 are an elaboration error.
- HOLD state:
  - Entered from reset, or from any state in the cycle after `emergency` is sampled high.
  - While in HOLD, `tmr_time_out` is ignored and no start is issued.
  - The first cycle `emergency` is sampled low in HOLD moves the controller to AR_B and issues a start.
- `ped_pending` (with `PED_REQ_EN`):
  - Set by `ped_req`=1. Cleared on entry to WALK. If set and clear coincide, set wins.
  - Retained through HOLD. Reset value is 0.
- `tmr_time_out` is honoured only in the ring states and only when `tmr_start` is 0 in that cycle. A time-out coincident with a start is discarded.

## Timing
- All outputs are registered.
- Reset values: state HOLD (7), `ns_light`=100, `ew_light`=100, `walk`=0, `tmr_start`=0, `tmr_tens`=0, `tmr_ones`=0.
- Reset asserted mid-phase forces these values on the next edge.
- Phase advance:
  - `tmr_time_out` sampled high at edge N in state S.
  - At edge N+1: state = S′, lamps = S′, `tmr_start`=1, and `tmr_tens`/`tmr_ones` = S′ duration.
  - At edge N+2: `tmr_start`=0, while the digits hold.
- `emergency` high takes priority over a simultaneous `tmr_time_out`: the next state is HOLD.
- Reset has priority over everything.
- `tmr_tens`/`tmr_ones` are stable for the whole phase. The timer may sample them at any cycle when `tmr_start`=1.

## Configuration
- `PED_REQ_EN` defined:
  - `ped_pending` register exists and the WALK state is reachable.
  - `walk` is driven as described under Operation.
- `PED_REQ_EN` undefined:
  - `ped_req` is ignored and no `ped_pending` register exists.
  - WALK is unreachable and `walk` is tied 0.
  - AR_B always proceeds to NS_G.

## Test plan
- Reset release (defaults):
  - Stimulus: `rst_n` high 2 cycles, then low.
  - Required: HOLD with all outputs at reset values; the first cycle after release gives state 0, `tmr_start`=1, digits 0/2, lamps 100/100.
- Full ring:
  - Stimulus: bench pulses `tmr_time_out` 5 cycles after each start.
  - Required: state sequence 0,1,2,3,4,5,0 with lamps as specified and digits 2/5 on green, 0/3 on yellow, 0/2 on all-red; exactly one `tmr_start` per phase.
- Pedestrian request (`PED_REQ_EN`):
  - Stimulus: `ped_req` pulse during NS_G.
  - Required: after EW_Y→AR_B, a time-out gives WALK with `walk`=1 and digits 1/0, then AR_B, then NS_G; a second request during WALK produces another WALK on the next ring.
- Emergency:
  - Stimulus: `emergency` asserted in EW_G, on the same cycle as a `tmr_time_out`.
  - Required: next state HOLD with both lamps 100 and no `tmr_start`; after release, AR_B with `tmr_start`=1.
- Spurious time-out:
  - Stimulus: `tmr_time_out` coincident with `tmr_start`, and a `tmr_time_out` while in HOLD.
  - Required: state unchanged in both cases.
- Without `PED_REQ_EN`:
  - Stimulus: `ped_req` held high.
  - Required: ring identical to the full-ring scenario and `walk` stays 0.
